assoc_datacache: RTL

Parametrised write-back, write-allocate data cache sitting between the CPU load/store stage and block-wide data memory. It replaces the single-cycle direct-mapped cache with a configurable 1- or 2-way set-associative array, byte-enabled stores, LRU replacement, and an explicit multi-cycle valid/ack handshake to memory, so a miss stalls the requester instead of completing within one edge.

---
 rtl/assoc_datacache_pkg.sv | 30 +++
 rtl/assoc_datacache_line_merge.sv | 42 ++++
 rtl/assoc_datacache.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/assoc_datacache_pkg.sv
// Shared definitions for the set-associative data cache.
//   - FSM state encoding (idle / write-back / fill / respond)
//   - BYTE_SIZE and helpers that derive the address-field widths
// Optional feature macro used by the top: DCACHE_STATS_EN (hit/miss counters).
package assoc_datacache_pkg;

  localparam int unsigned BYTE_SIZE = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWb   = 2'd1,
    StFill = 2'd2,
    StResp = 2'd3
  } state_e;

  // Byte-offset width of a line: words are 4 bytes wide.
  function automatic int unsigned off_bits(input int unsigned block_words);
    return $clog2(block_words * 4);
  endfunction

  function automatic int unsigned idx_bits(input int unsigned sets);
    return $clog2(sets);
  endfunction

  // Signal widths must be at least one bit even when a field is empty.
  function automatic int unsigned min1(input int unsigned v);
    return (v == 0) ? 1 : v;
  endfunction

endpackage

// File: rtl/assoc_datacache_line_merge.sv
// Combinational word select and byte-enable merge into a cache line.
// Ports:
//   line_in   - current line contents (word 0 in the LSBs)
//   word_sel  - word within the line
//   write     - apply the byte-enabled store
//   wdata/be  - store data and byte enables
//   line_out  - line with the merged word
//   word_out  - selected word after the merge (the load/store response word)
module assoc_datacache_line_merge
  import assoc_datacache_pkg::*;
#(
  parameter int unsigned WORD_SIZE   = 32,
  parameter int unsigned BLOCK_WORDS = 8
) (
  input  logic [WORD_SIZE*BLOCK_WORDS-1:0] line_in,
  input  logic [$clog2(BLOCK_WORDS)-1:0]   word_sel,
  input  logic                             write,
  input  logic [WORD_SIZE-1:0]             wdata,
  input  logic [WORD_SIZE/BYTE_SIZE-1:0]   be,
  output logic [WORD_SIZE*BLOCK_WORDS-1:0] line_out,
  output logic [WORD_SIZE-1:0]             word_out
);

  localparam int unsigned BE_W = WORD_SIZE / BYTE_SIZE;

  logic [WORD_SIZE-1:0] old_word;
  logic [WORD_SIZE-1:0] new_word;

  always_comb begin
    old_word = line_in[word_sel*WORD_SIZE +: WORD_SIZE];
    new_word = old_word;
    if (write) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) new_word[i*BYTE_SIZE +: BYTE_SIZE] = wdata[i*BYTE_SIZE +: BYTE_SIZE];
      end
    end
    line_out = line_in;
    line_out[word_sel*WORD_SIZE +: WORD_SIZE] = new_word;
    word_out = new_word;
  end

endmodule

// File: rtl/assoc_datacache.sv
// Write-back, write-allocate, 1- or 2-way set-associative data cache with LRU
// replacement and a valid/ack handshake to block-wide memory.
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   req_*                        - CPU request (valid, write, addr, wdata, be), req_ready
//   resp_valid, resp_rdata       - one-cycle completion pulse and result word
//   mem_req/we/addr/wdata        - memory transaction (write-back or fill)
//   mem_ack, mem_rdata           - memory completion and fill line
//   hit_count, miss_count        - saturating counters, only with DCACHE_STATS_EN
module assoc_datacache
  import assoc_datacache_pkg::*;
#(
  parameter int unsigned WORD_SIZE   = 32,
  parameter int unsigned BLOCK_WORDS = 8,
  parameter int unsigned SETS        = 4,
  parameter int unsigned WAYS        = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  input  logic                             req_write,
  input  logic [WORD_SIZE-1:0]             req_addr,
  input  logic [WORD_SIZE-1:0]             req_wdata,
  input  logic [WORD_SIZE/BYTE_SIZE-1:0]   req_be,
  output logic                             req_ready,
  output logic                             resp_valid,
  output logic [WORD_SIZE-1:0]             resp_rdata,
  output logic                             mem_req,
  output logic                             mem_we,
  output logic [WORD_SIZE-1:0]             mem_addr,
  output logic [WORD_SIZE*BLOCK_WORDS-1:0] mem_wdata,
  input  logic                             mem_ack,
  input  logic [WORD_SIZE*BLOCK_WORDS-1:0] mem_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]                      hit_count,
  output logic [31:0]                      miss_count
`endif
);

  localparam int unsigned OFF_W  = off_bits(BLOCK_WORDS);
  localparam int unsigned SEL_W  = $clog2(BLOCK_WORDS);
  localparam int unsigned IDX_B  = idx_bits(SETS);
  localparam int unsigned IDX_W  = min1(IDX_B);
  localparam int unsigned TAG_W  = WORD_SIZE - OFF_W - IDX_B;
  localparam int unsigned LINE_W = WORD_SIZE * BLOCK_WORDS;
  localparam int unsigned BE_W   = WORD_SIZE / BYTE_SIZE;

  state_e state_q, state_d;

  // Line state arrays.
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];
  logic [SETS-1:0]   lru_q;
  logic [TAG_W-1:0]  tags_q  [SETS][WAYS];
  logic [LINE_W-1:0] data_q  [SETS][WAYS];

  // Request held across a miss.
  logic [IDX_W-1:0]     req_idx_q;
  logic [TAG_W-1:0]     req_tag_q;
  logic [SEL_W-1:0]     req_sel_q;
  logic                 write_q;
  logic [WORD_SIZE-1:0] wdata_q;
  logic [BE_W-1:0]      be_q;
  logic                 victim_q;

  logic                 resp_valid_q;
  logic [WORD_SIZE-1:0] resp_rdata_q;

  // Live address decode.
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [SEL_W-1:0] req_sel;
  logic             unused_addr_bits;

  assign req_tag = req_addr[WORD_SIZE-1 -: TAG_W];
  assign req_sel = req_addr[OFF_W-1:2];
  assign unused_addr_bits = ^req_addr[1:0];

  if (IDX_B > 0) begin : g_idx
    assign req_idx = req_addr[OFF_W +: IDX_W];
  end else begin : g_no_idx
    assign req_idx = '0;
  end

  function automatic logic [WORD_SIZE-1:0] line_addr(input logic [TAG_W-1:0] t,
                                                     input logic [IDX_W-1:0] i);
    logic [WORD_SIZE-1:0] a;
    a = '0;
    if (IDX_B > 0) a[OFF_W +: IDX_W] = i;
    a[WORD_SIZE-1 -: TAG_W] = t;
    return a;
  endfunction

  // Lookup and victim choice.
  logic [WAYS-1:0] hit_vec;
  logic            hit;
  logic            hit_way;
  logic            vic_way;
  logic            vic_dirty;
  logic            accept;
  logic            hit_acc;
  logic            miss_acc;

  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid_q[req_idx][w] && (tags_q[req_idx][w] == req_tag);
    end
    hit     = |hit_vec;
    hit_way = (WAYS == 2) ? hit_vec[WAYS-1] : 1'b0;

    // Invalid ways fill first (way 0 before way 1), otherwise the LRU way.
    if (!valid_q[req_idx][0])                          vic_way = 1'b0;
    else if ((WAYS == 2) && !valid_q[req_idx][WAYS-1]) vic_way = 1'b1;
    else                                               vic_way = (WAYS == 2) ? lru_q[req_idx] : 1'b0;
    vic_dirty = valid_q[req_idx][vic_way] && dirty_q[req_idx][vic_way];
  end

  assign req_ready = (state_q == StIdle) && !rst;
  assign accept    = req_ready && req_valid;
  assign hit_acc   = accept && hit;
  assign miss_acc  = accept && !hit;

  // One merge unit, shared by the hit path (live request) and RESP (held request).
  logic [LINE_W-1:0]    m_line;
  logic [SEL_W-1:0]     m_sel;
  logic                 m_write;
  logic [WORD_SIZE-1:0] m_wdata;
  logic [BE_W-1:0]      m_be;
  logic [LINE_W-1:0]    m_line_new;
  logic [WORD_SIZE-1:0] m_word;

  always_comb begin
    if (state_q == StResp) begin
      m_line  = data_q[req_idx_q][victim_q];
      m_sel   = req_sel_q;
      m_write = write_q;
      m_wdata = wdata_q;
      m_be    = be_q;
    end else begin
      m_line  = data_q[req_idx][hit_way];
      m_sel   = req_sel;
      m_write = req_write;
      m_wdata = req_wdata;
      m_be    = req_be;
    end
  end

  assoc_datacache_line_merge #(
    .WORD_SIZE  (WORD_SIZE),
    .BLOCK_WORDS(BLOCK_WORDS)
  ) u_merge (
    .line_in (m_line),
    .word_sel(m_sel),
    .write   (m_write),
    .wdata   (m_wdata),
    .be      (m_be),
    .line_out(m_line_new),
    .word_out(m_word)
  );

  // Next state and memory-side outputs. Memory outputs derive only from
  // registered state, so they hold steady until the acking edge.
  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      StIdle: begin
        if (miss_acc) state_d = vic_dirty ? StWb : StFill;
      end
      StWb: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = line_addr(tags_q[req_idx_q][victim_q], req_idx_q);
        mem_wdata = data_q[req_idx_q][victim_q];
        if (mem_ack) state_d = StFill;
      end
      StFill: begin
        mem_req  = 1'b1;
        mem_addr = line_addr(req_tag_q, req_idx_q);
        if (mem_ack) state_d = StResp;
      end
      StResp: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state, line flags and response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      lru_q        <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else begin
      state_q      <= state_d;
      resp_valid_q <= 1'b0;
      if (hit_acc) begin
        resp_valid_q <= 1'b1;
        resp_rdata_q <= m_word;
        if (req_write) dirty_q[req_idx][hit_way] <= 1'b1;
        if (WAYS == 2) lru_q[req_idx] <= ~hit_way;
      end
      if ((state_q == StFill) && mem_ack) begin
        valid_q[req_idx_q][victim_q] <= 1'b1;
        dirty_q[req_idx_q][victim_q] <= 1'b0;
      end
      if (state_q == StResp) begin
        resp_valid_q <= 1'b1;
        resp_rdata_q <= m_word;
        if (write_q) dirty_q[req_idx_q][victim_q] <= 1'b1;
        if (WAYS == 2) lru_q[req_idx_q] <= ~victim_q;
      end
    end
  end

  // Line data, tags and held request need no reset: valid bits guard them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (hit_acc && req_write) data_q[req_idx][hit_way] <= m_line_new;
      if (miss_acc) begin
        req_idx_q <= req_idx;
        req_tag_q <= req_tag;
        req_sel_q <= req_sel;
        write_q   <= req_write;
        wdata_q   <= req_wdata;
        be_q      <= req_be;
        victim_q  <= vic_way;
      end
      if ((state_q == StFill) && mem_ack) begin
        data_q[req_idx_q][victim_q] <= mem_rdata;
        tags_q[req_idx_q][victim_q] <= req_tag_q;
      end
      if ((state_q == StResp) && write_q) data_q[req_idx_q][victim_q] <= m_line_new;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit_acc && (hit_count != '1))   hit_count  <= hit_count + 32'd1;
      if (miss_acc && (miss_count != '1)) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule
